// File: rtl/cf_fft_1024_8_unload_if.sv
// Stream bundle around the FFT unload buffer: the unflow-controlled input
// stream from the last butterfly stage, the clock enable, and the
// valid/ready output stream towards the consumer.
interface cf_fft_1024_8_unload_if #(
   parameter int W = 16
);
   logic         i1;
   logic [W-1:0] i2;
   logic [W-1:0] i3;
   logic         i4;
   logic         i6;
   logic         o1;
   logic [W-1:0] o2;
   logic [W-1:0] o3;
   logic         o4;
   logic         o5;
   logic         o6;

   modport master (output i1, i2, i3, i4, i6, input o1, o2, o3, o4, o5, o6);
   modport slave  (input i1, i2, i3, i4, i6, output o1, o2, o3, o4, o5, o6);
endinterface

// File: rtl/cf_fft_1024_8_unload.sv
// Output reorder/unload buffer for the streaming FFT. Bit-reversed frames
// are written into a two-bank ping-pong RAM, then drained in natural order
// through a 2-entry skid buffer towards a consumer that may stall.
module cf_fft_1024_8_unload #(
   parameter int N    = 1024,
   parameter int LOGN = 10,
   parameter int W    = 16
) (
   input logic                   clock_c,
   input logic                   i5,
   cf_fft_1024_8_unload_if.slave bus
);
   localparam int EW = 2 * W + 2;
   localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

   typedef enum logic [1:0] {EMPTY, FULL, DRAINING} bank_t;
   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
      logic [LOGN-1:0] r;
      for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
      return r;
   endfunction

   logic [2*W-1:0]  mem [0:2*N-1];
   bank_t           bank_st [2];
   logic [LOGN-1:0] wcnt;
   logic            wsel;
   logic            frame_ok;
   logic            overflow;
   logic            rsel;
   logic            rbank;
   logic [LOGN-1:0] raddr;
   logic            all_issued;
   state_t          state;
   state_t          state_next;
   logic            issue;
   logic            start;
   logic            pend;
   logic            pend_first;
   logic            pend_last;
   logic [2*W-1:0]  rd_data;
   logic [EW-1:0]   slot0;
   logic [EW-1:0]   slot1;
   logic [1:0]      cnt;
   logic            beat;
   logic            wr_ok;
   logic            wr_en;
   logic            pop;
   logic            room;
   logic            free;
   logic [2:0]      occ;
   logic [1:0]      wi;

   // A frame's fate is decided on its first beat and remembered for the rest
   assign beat  = bus.i4 && bus.i1;
   assign wr_ok = (wcnt == '0) ? (bank_st[wsel] == EMPTY) : frame_ok;
   assign wr_en = beat && wr_ok;

   // Skid slot 0 is the head; a read may only be issued if its data is sure
   // to find a slot when it returns, counting the read already in flight
   assign pop  = bus.i4 && bus.i6 && (cnt != 2'd0);
   assign free = pop && slot0[EW-2];
   assign occ  = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
   assign room = bus.i4 && (occ <= 3'd1);
   assign wi   = cnt - {1'b0, pop};

   assign bus.o1 = (cnt != 2'd0);
   assign bus.o2 = slot0[2*W-1:W];
   assign bus.o3 = slot0[W-1:0];
   assign bus.o4 = bus.o1 && slot0[EW-2];
   assign bus.o5 = bus.o1 && slot0[EW-1];
   assign bus.o6 = overflow;

   // Read FSM state register
   always_ff @(posedge clock_c) begin
      if (i5) state <= IDLE;
      else if (bus.i4) state <= state_next;
   end

   // Read FSM: start a full bank as soon as the previous one is fully issued
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (bank_st[rbank] == FULL && room) begin
               start      = 1'b1;
               issue      = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (!all_issued) begin
               issue = room;
            end else if (bank_st[rbank] == FULL) begin
               start = room;
               issue = room;
            end else if (cnt == 2'd0 && !pend) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Ping-pong RAM with a one-cycle registered read port
   always_ff @(posedge clock_c) begin
      if (wr_en) mem[{wsel, bitrev(wcnt)}] <= {bus.i2, bus.i3};
      if (issue) rd_data <= mem[{rbank, raddr}];
   end

   // Bank states, write/read pointers and overflow flag
   always_ff @(posedge clock_c) begin
      if (i5) begin
         bank_st[0] <= EMPTY;
         bank_st[1] <= EMPTY;
         wcnt       <= '0;
         wsel       <= 1'b0;
         frame_ok   <= 1'b0;
         overflow   <= 1'b0;
         rsel       <= 1'b0;
         rbank      <= 1'b0;
         raddr      <= '0;
         all_issued <= 1'b0;
         pend       <= 1'b0;
         pend_first <= 1'b0;
         pend_last  <= 1'b0;
      end else if (bus.i4) begin
         if (beat) begin
            wcnt <= wcnt + LOGN'(1);
            if (wcnt == '0) begin
               frame_ok <= (bank_st[wsel] == EMPTY);
               if (bank_st[wsel] != EMPTY) overflow <= 1'b1;
            end
            if (wr_en && wcnt == LAST) begin
               bank_st[wsel] <= FULL;
               wsel          <= ~wsel;
            end
         end
         pend <= issue;
         if (issue) begin
            raddr      <= raddr + LOGN'(1);
            pend_first <= (raddr == '0);
            pend_last  <= (raddr == LAST);
            if (raddr == LAST) begin
               all_issued <= 1'b1;
               rbank      <= ~rbank;
            end
         end
         if (start) begin
            bank_st[rbank] <= DRAINING;
            all_issued     <= 1'b0;
         end
         if (free) begin
            bank_st[rsel] <= EMPTY;
            rsel          <= ~rsel;
         end
      end
   end

   // Two-entry skid buffer: head only moves on a pop so stalls hold outputs
   always_ff @(posedge clock_c) begin
      if (i5) begin
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= 2'd0;
      end else if (bus.i4) begin
         if (pop) slot0 <= slot1;
         if (pend) begin
            if (wi == 2'd0) slot0 <= {pend_first, pend_last, rd_data};
            else slot1 <= {pend_first, pend_last, rd_data};
         end
         cnt <= cnt + {1'b0, pend} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_cf_fft_1024_8_unload.sv
// Self-checking bench for the FFT unload buffer (N=8): directed scenarios
// with literal expectations plus randomized traffic against a frame-level
// reference model of the ping-pong banks.
module tb_cf_fft_1024_8_unload;
   localparam int N    = 8;
   localparam int LOGN = 3;
   localparam int W    = 16;

   logic clock_c = 1'b0;
   logic i5      = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   bit   armed   = 1'b0;

   cf_fft_1024_8_unload_if #(.W(W)) bus ();

   cf_fft_1024_8_unload #(.N(N), .LOGN(LOGN), .W(W)) dut (
      .clock_c (clock_c),
      .i5      (i5),
      .bus     (bus)
   );

   always #5 clock_c = ~clock_c;

   always @(posedge clock_c) cyc <= cyc + 1;

   // Reference model state: expected natural-order beats and bank occupancy
   logic [33:0] exp_q [$];
   logic [31:0] m_frame [N];
   int          m_wcnt   = 0;
   bit          m_accept = 1'b0;
   bit          m_o6     = 1'b0;
   bit          m_wsel   = 1'b0;
   bit          m_rsel   = 1'b0;
   bit          m_occ [2];
   bit          hold_prev = 1'b0;
   logic [33:0] head;
   logic [33:0] e;
   int          seen_re [$];
   int          seen_im [$];
   int          seen_first [$];
   int          seen_last [$];
   int          seen_cyc [$];
   int          br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   function automatic int brev(input int v);
      int r = 0;
      for (int b = 0; b < LOGN; b++) if (v[b]) r = r | (1 << (LOGN - 1 - b));
      return r;
   endfunction

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Compare outputs against the model, then advance the model through the
   // coming rising edge using the inputs that edge will see
   always @(negedge clock_c) begin
      if (armed) begin
         check_output("o6", bus.o6, m_o6);
         if (hold_prev) check_output("hold_valid", bus.o1, 1);
         if (bus.o1) begin
            if (exp_q.size() == 0) check_output("unexpected_valid", 1, 0);
            else check_output("beat", {bus.o5, bus.o4, bus.o2, bus.o3}, exp_q[0]);
         end
      end
      hold_prev = 1'b0;
      if (i5) begin
         exp_q.delete();
         m_wcnt   = 0;
         m_accept = 1'b0;
         m_o6     = 1'b0;
         m_wsel   = 1'b0;
         m_rsel   = 1'b0;
         m_occ[0] = 1'b0;
         m_occ[1] = 1'b0;
      end else if (bus.i4) begin
         if (bus.i1) begin
            if (m_wcnt == 0) begin
               m_accept = !m_occ[m_wsel];
               if (!m_accept) m_o6 = 1'b1;
            end
            m_frame[m_wcnt] = {bus.i2, bus.i3};
            if (m_wcnt == N - 1 && m_accept) begin
               for (int j = 0; j < N; j++) begin
                  e = {(j == 0), (j == N - 1), m_frame[brev(j)]};
                  exp_q.push_back(e);
               end
               m_occ[m_wsel] = 1'b1;
               m_wsel = !m_wsel;
            end
            m_wcnt = (m_wcnt + 1) % N;
         end
         if (bus.o1 && bus.i6) begin
            seen_re.push_back(int'(bus.o2));
            seen_im.push_back(int'(bus.o3));
            seen_first.push_back(int'(bus.o5));
            seen_last.push_back(int'(bus.o4));
            seen_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
               head = exp_q.pop_front();
               if (head[32]) begin
                  m_occ[m_rsel] = 1'b0;
                  m_rsel = !m_rsel;
               end
            end
         end
         hold_prev = bus.o1 && !bus.i6;
      end else begin
         hold_prev = bus.o1;
      end
   end

   task automatic tick();
      @(posedge clock_c);
      #1;
   endtask

   task automatic idle(input int n);
      bus.i1 = 1'b0;
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic do_reset();
      bus.i1 = 1'b0;
      i5 = 1'b1;
      tick();
      tick();
      i5 = 1'b0;
   endtask

   task automatic clear_seen();
      seen_re.delete();
      seen_im.delete();
      seen_first.delete();
      seen_last.delete();
      seen_cyc.delete();
   endtask

   task automatic send_beat(input int re, input int im);
      bus.i1 = 1'b1;
      bus.i2 = 16'(re);
      bus.i3 = 16'(im);
      tick();
   endtask

   // One frame: real = base+k, imag = 100+base+k; optional 5-cycle enable drop
   task automatic send_frame(input int base, input int first_k, input int freeze_at);
      for (int k = first_k; k < N; k++) begin
         if (k == freeze_at) begin
            bus.i4 = 1'b0;
            for (int c = 0; c < 5; c++) send_beat(16'hdead, 16'hbeef);
            bus.i4 = 1'b1;
         end
         send_beat(base + k, 100 + base + k);
      end
   endtask

   task automatic wait_seen(input int n, input int limit, input string name);
      int c = 0;
      while (seen_re.size() < n && c < limit) begin
         tick();
         c++;
      end
      check_output(name, seen_re.size() >= n, 1);
   endtask

   // Natural-order content of one frame written with the given base
   task automatic check_frame(input int base, input int off);
      for (int j = 0; j < N; j++) begin
         check_output("order_re", seen_re[off + j], base + br8[j]);
         check_output("order_im", seen_im[off + j], 100 + base + br8[j]);
         check_output("order_first", seen_first[off + j], (j == 0) ? 1 : 0);
         check_output("order_last", seen_last[off + j], (j == N - 1) ? 1 : 0);
      end
   endtask

   task automatic apply_stimulus_random(input int n);
      for (int c = 0; c < n; c++) begin
         i5     = ($urandom_range(0, 299) == 0);
         bus.i4 = ($urandom_range(0, 7) != 0);
         bus.i1 = ($urandom_range(0, 3) != 0);
         bus.i6 = ($urandom_range(0, 2) != 0);
         bus.i2 = 16'($urandom);
         bus.i3 = 16'($urandom);
         tick();
      end
      i5 = 1'b0;
   endtask

   initial begin
      bus.i1 = 1'b0;
      bus.i2 = '0;
      bus.i3 = '0;
      bus.i4 = 1'b1;
      bus.i6 = 1'b1;
      tick();
      armed = 1'b1;
      do_reset();

      // Reset state
      check_output("rst_o1", bus.o1, 0);
      check_output("rst_o2", bus.o2, 0);
      check_output("rst_o3", bus.o3, 0);
      check_output("rst_o4", bus.o4, 0);
      check_output("rst_o5", bus.o5, 0);
      check_output("rst_o6", bus.o6, 0);

      // Order and latency
      $display("[TB] order test");
      clear_seen();
      send_frame(0, 0, -1);
      bus.i1 = 1'b0;
      check_output("lat_t0_o1", bus.o1, 0);
      tick();
      check_output("lat_t1_o1", bus.o1, 0);
      tick();
      check_output("lat_t2_o1", bus.o1, 1);
      check_output("lat_t2_o5", bus.o5, 1);
      check_output("lat_t2_o2", bus.o2, 0);
      check_output("lat_t2_o3", bus.o3, 100);
      wait_seen(8, 40, "order_timeout");
      check_frame(0, 0);

      // Backpressure with a repeating ready pattern
      $display("[TB] backpressure test");
      do_reset();
      clear_seen();
      send_frame(0, 0, -1);
      bus.i1 = 1'b0;
      begin
         int pat [6] = '{1, 0, 0, 1, 0, 1};
         int p = 0;
         while (seen_re.size() < 8 && p < 80) begin
            bus.i6 = pat[p % 6] != 0;
            tick();
            p++;
         end
      end
      bus.i6 = 1'b1;
      check_output("bp_count", seen_re.size(), 8);
      idle(10);
      check_output("bp_exact", seen_re.size(), 8);
      check_frame(0, 0);

      // Ping-pong: two frames back to back, a third after a short gap
      $display("[TB] ping-pong test");
      do_reset();
      clear_seen();
      send_frame(0, 0, -1);
      send_frame(8, 0, -1);
      idle(3);
      send_frame(16, 0, -1);
      bus.i1 = 1'b0;
      wait_seen(24, 80, "pp_timeout");
      check_frame(0, 0);
      check_frame(8, 8);
      check_frame(16, 16);
      check_output("pp_no_bubble", seen_cyc[15] - seen_cyc[0], 15);
      check_output("pp_o6", bus.o6, 0);

      // Enable held low mid-input and mid-output
      $display("[TB] enable test");
      do_reset();
      clear_seen();
      send_frame(0, 0, 4);
      bus.i1 = 1'b0;
      wait_seen(3, 40, "en_timeout_a");
      bus.i4 = 1'b0;
      idle(5);
      bus.i4 = 1'b1;
      wait_seen(8, 40, "en_timeout_b");
      idle(10);
      check_output("en_exact", seen_re.size(), 8);
      check_frame(0, 0);

      // Overflow: third frame arrives while both banks are occupied
      $display("[TB] overflow test");
      do_reset();
      clear_seen();
      bus.i6 = 1'b0;
      send_frame(0, 0, -1);
      send_frame(8, 0, -1);
      check_output("ovf_before", bus.o6, 0);
      send_beat(16, 116);
      check_output("ovf_set", bus.o6, 1);
      send_frame(16, 1, -1);
      bus.i1 = 1'b0;
      bus.i6 = 1'b1;
      wait_seen(16, 80, "ovf_timeout");
      idle(20);
      check_output("ovf_exact", seen_re.size(), 16);
      check_frame(0, 0);
      check_frame(8, 8);

      // Reset in the middle of a drain, then a fresh frame
      $display("[TB] reset mid-drain test");
      clear_seen();
      send_frame(0, 0, -1);
      bus.i1 = 1'b0;
      wait_seen(3, 40, "rst_timeout_a");
      check_output("rst_o6_before", bus.o6, 1);
      i5 = 1'b1;
      tick();
      i5 = 1'b0;
      check_output("rst_mid_o1", bus.o1, 0);
      check_output("rst_mid_o6", bus.o6, 0);
      clear_seen();
      send_frame(0, 0, -1);
      bus.i1 = 1'b0;
      wait_seen(8, 40, "rst_timeout_b");
      check_frame(0, 0);

      // Randomized traffic, then drain everything the model still expects
      $display("[TB] random test");
      do_reset();
      apply_stimulus_random(1500);
      bus.i1 = 1'b0;
      bus.i4 = 1'b1;
      bus.i6 = 1'b1;
      begin
         int c = 0;
         while (exp_q.size() > 0 && c < 200) begin
            tick();
            c++;
         end
      end
      idle(4);
      check_output("drain_empty", exp_q.size(), 0);
      check_output("drain_o1", bus.o1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
